// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_NEURONS parallel leaky integrate-and-fire neurons that
// share one programmable threshold. Each neuron has a shift-based leak,
// saturating integration, a one-cycle spike pulse and a refractory period.
module lif_neuron_array #(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned STATE_W    = 8,
  parameter int unsigned IN_W       = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRACT    = 2,
  parameter int unsigned THR_RESET  = 200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [N_NEURONS*IN_W-1:0]      cur_in,
  input  logic                           thr_we,
  input  logic [STATE_W-1:0]             thr_in,
  output logic [N_NEURONS-1:0]           spike_out,
  output logic                           spike_any,
  output logic [N_NEURONS*STATE_W-1:0]   v_out,
  output logic [N_NEURONS-1:0]           refr_out,
  output logic [STATE_W-1:0]             thr_out
);

  localparam int unsigned R_W   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int unsigned SUM_W = STATE_W + 1;
  localparam logic [STATE_W-1:0] V_MAX = '1;

  logic [STATE_W-1:0] v_q    [N_NEURONS];
  logic [STATE_W-1:0] v_d    [N_NEURONS];
  logic [R_W-1:0]     r_q    [N_NEURONS];
  logic [R_W-1:0]     r_d    [N_NEURONS];
  logic [STATE_W-1:0] leak   [N_NEURONS];
  logic [SUM_W-1:0]   sum    [N_NEURONS];
  logic [STATE_W-1:0] sat    [N_NEURONS];
  logic [N_NEURONS-1:0] spike_d;
  logic [N_NEURONS-1:0] refr_d;
  logic [STATE_W-1:0] thr_q;

  // Per-neuron next state: leak, saturating integrate, fire/refractory.
  always_comb begin
    for (int k = 0; k < N_NEURONS; k++) begin
      leak[k]    = v_q[k] - (v_q[k] >> LEAK_SHIFT);
      sum[k]     = SUM_W'(leak[k]) + SUM_W'(cur_in[k*IN_W +: IN_W]);
      sat[k]     = sum[k][STATE_W] ? V_MAX : sum[k][STATE_W-1:0];
      v_d[k]     = v_q[k];
      r_d[k]     = r_q[k];
      spike_d[k] = 1'b0;
      if (ena) begin
        if (r_q[k] != '0) begin
          // Refractory: input ignored, membrane clamped at rest.
          r_d[k] = r_q[k] - R_W'(1);
          v_d[k] = '0;
        end else if (sat[k] >= thr_q) begin
          spike_d[k] = 1'b1;
          v_d[k]     = '0;
          r_d[k]     = R_W'(REFRACT);
        end else begin
          v_d[k] = sat[k];
        end
      end
      refr_d[k] = (r_d[k] != '0);
    end
  end

  // Neuron state and registered per-neuron outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= '0;
        r_q[k] <= '0;
      end
      spike_out <= '0;
      spike_any <= 1'b0;
      refr_out  <= '0;
    end else begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= v_d[k];
        r_q[k] <= r_d[k];
      end
      spike_out <= spike_d;
      spike_any <= |spike_d;
      refr_out  <= refr_d;
    end
  end

  // Shared threshold; an update on the same edge still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= STATE_W'(THR_RESET);
    end else if (thr_we) begin
      thr_q <= thr_in;
    end
  end

  // Pack membrane registers onto the flat tap bus.
  always_comb begin
    for (int k = 0; k < N_NEURONS; k++) begin
      v_out[k*STATE_W +: STATE_W] = v_q[k];
    end
  end

  assign thr_out = thr_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array with hand-computed expectations.
module tb_lif_neuron_array;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [31:0] cur_in;
  logic        thr_we;
  logic [7:0]  thr_in;
  logic [3:0]  spike_out;
  logic        spike_any;
  logic [31:0] v_out;
  logic [3:0]  refr_out;
  logic [7:0]  thr_out;

  int total;
  int bad;

  lif_neuron_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cur_in    (cur_in),
    .thr_we    (thr_we),
    .thr_in    (thr_in),
    .spike_out (spike_out),
    .spike_any (spike_any),
    .v_out     (v_out),
    .refr_out  (refr_out),
    .thr_out   (thr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] vk(input int k);
    return v_out[k*8 +: 8];
  endfunction

  task automatic set_cur(input int k, input logic [7:0] val);
    cur_in[k*8 +: 8] = val;
  endtask

  // One clock edge; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    thr_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b0;
    thr_we = 1'b0;
    thr_in = 8'd0;
    cur_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] leak_seq [5];
  logic [3:0] spk_seen;

  initial begin
    total = 0;
    bad   = 0;
    leak_seq[0] = 8'd15; leak_seq[1] = 8'd29; leak_seq[2] = 8'd41;
    leak_seq[3] = 8'd51; leak_seq[4] = 8'd60;

    // Reset held with activity on the inputs.
    rst_n = 1'b0; ena = 1'b1; thr_we = 1'b0; thr_in = 8'd0;
    cur_in = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v", v_out, 32'd0);
    chk("rst_spike", spike_out, 4'd0);
    chk("rst_any", spike_any, 1'b0);
    chk("rst_refr", refr_out, 4'd0);
    chk("rst_thr", thr_out, 8'd200);

    // Leak convergence on neuron 0.
    cur_in = '0; ena = 1'b0;
    rst_n = 1'b1;
    ena = 1'b1;
    set_cur(0, 8'd15);
    spk_seen = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("leak_v0_%0d", i), vk(0), leak_seq[i]);
      spk_seen |= spike_out;
    end
    for (int i = 5; i < 64; i++) begin
      step();
      spk_seen |= spike_out;
    end
    chk("leak_settle", vk(0), 8'd120);
    step();
    chk("leak_stay", vk(0), 8'd120);
    chk("leak_nospike", spk_seen, 4'd0);

    // Spike, refractory and enable gating.
    do_reset();
    ena = 1'b1;
    set_cur(0, 8'd15);
    set_cur(1, 8'd240);
    step();
    chk("s1_spike", spike_out, 4'b0010);
    chk("s1_any", spike_any, 1'b1);
    chk("s1_v1", vk(1), 8'd0);
    chk("s1_refr", refr_out, 4'b0010);
    chk("s1_v0", vk(0), 8'd15);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("gate_spike_%0d", i), spike_out, 4'd0);
      chk($sformatf("gate_any_%0d", i), spike_any, 1'b0);
      chk($sformatf("gate_v_%0d", i), v_out, {8'd0, 8'd0, 8'd0, 8'd15});
      chk($sformatf("gate_refr_%0d", i), refr_out, 4'b0010);
    end
    ena = 1'b1;
    step();
    chk("s2_spike", spike_out, 4'd0);
    chk("s2_refr", refr_out, 4'b0010);
    chk("s2_v", v_out, {8'd0, 8'd0, 8'd0, 8'd29});
    step();
    chk("s3_spike", spike_out, 4'd0);
    chk("s3_refr", refr_out, 4'b0000);
    chk("s3_v", v_out, {8'd0, 8'd0, 8'd0, 8'd41});
    step();
    chk("s4_spike", spike_out, 4'b0010);
    chk("s4_refr", refr_out, 4'b0010);
    chk("s4_v", v_out, {8'd0, 8'd0, 8'd0, 8'd51});

    // Saturation at maximum threshold; write while disabled.
    do_reset();
    thr_we = 1'b1; thr_in = 8'd255;
    step();
    chk("sat_thr", thr_out, 8'd255);
    chk("sat_idle_v", v_out, 32'd0);
    ena = 1'b1;
    set_cur(2, 8'd200);
    step();
    chk("sat_v2_a", vk(2), 8'd200);
    chk("sat_spk_a", spike_out, 4'd0);
    step();
    chk("sat_v2_b", vk(2), 8'd0);
    chk("sat_spk_b", spike_out, 4'b0100);

    // Threshold write on the same edge as an update uses the old value.
    do_reset();
    ena = 1'b1;
    set_cur(3, 8'd100);
    thr_we = 1'b1; thr_in = 8'd50;
    step();
    chk("wo_spike", spike_out, 4'd0);
    chk("wo_v3", vk(3), 8'd100);
    chk("wo_thr", thr_out, 8'd50);
    set_cur(3, 8'd0);
    step();
    chk("wo_spike2", spike_out, 4'b1000);
    chk("wo_v3b", vk(3), 8'd0);

    // Zero threshold: every idle neuron fires.
    do_reset();
    thr_we = 1'b1; thr_in = 8'd0;
    step();
    ena = 1'b1;
    step();
    chk("thr0_spike", spike_out, 4'b1111);
    chk("thr0_refr", refr_out, 4'b1111);

    // Asynchronous reset mid-refractory.
    do_reset();
    thr_we = 1'b1; thr_in = 8'd60;
    step();
    ena = 1'b1;
    set_cur(1, 8'd240);
    set_cur(0, 8'd15);
    step();
    chk("ar_pre_refr", refr_out, 4'b0010);
    chk("ar_pre_thr", thr_out, 8'd60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_v", v_out, 32'd0);
    chk("ar_refr", refr_out, 4'd0);
    chk("ar_spike", spike_out, 4'd0);
    chk("ar_thr", thr_out, 8'd200);
    #1;
    rst_n = 1'b1;
    set_cur(1, 8'd0);
    step();
    chk("ar_fresh_v0", vk(0), 8'd15);
    chk("ar_fresh_spk", spike_out, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
